// File: rtl/reaction_recorder_if.sv
// Signal bundle between the game control/display side and reaction_recorder.
// The master side drives state, player and button. The slave side returns the timing results.
interface reaction_recorder_if;
  logic [2:0] machine_state;
  logic       cur_player;
  logic       btn;
  logic       press;
  logic       false_start;
  logic [9:0] react_time;
  logic [9:0] avr_react_time_A;
  logic [9:0] avr_react_time_B;
  logic       avg_busy;
  logic       avg_done;

  modport master (
    output machine_state, cur_player, btn,
    input  press, false_start, react_time, avr_react_time_A, avr_react_time_B,
           avg_busy, avg_done
  );

  modport slave (
    input  machine_state, cur_player, btn,
    output press, false_start, react_time, avr_react_time_A, avr_react_time_B,
           avg_busy, avg_done
  );
endinterface

// File: rtl/reaction_recorder.sv
// Reaction timer: debounced button, millisecond reaction count, per-player sums
// and a serial restoring divider that produces the per-player averages.
module reaction_recorder #(
  parameter int unsigned MS_DIV       = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned TRIALS       = 5
) (
  input  logic                clk,
  input  logic                rstn,
  reaction_recorder_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_CLR_CNT1 = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_STORAGE  = 3'd4;
  localparam logic [2:0] S_CLR_CNT2 = 3'd5;
  localparam logic [2:0] S_AVERAGE  = 3'd6;

  localparam int unsigned MS_W = ($clog2(MS_DIV) < 1) ? 1 : $clog2(MS_DIV);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(MS_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [4:0]      TRIALS_C = 5'(TRIALS);
  localparam logic [9:0]      RT_MAX   = 10'd999;

  logic            r_sync1, r_sync2, r_db_level, r_db_prev, r_press;
  logic [DB_W-1:0] r_db_cnt;
  logic [MS_W-1:0] r_ms_cnt;
  logic [9:0]      r_rt;
  logic [2:0]      r_prev_state;
  logic [13:0]     r_sum [2];
  logic [4:0]      r_cnt [2];
  logic            r_busy, r_done, r_div_player;
  logic [13:0]     r_div_q;
  logic [4:0]      r_div_rem, r_div_d;
  logic [3:0]      r_step;
  logic [9:0]      r_avg_a, r_avg_b;

  logic            w_tick, w_store_entry, w_avg_entry, w_fit;
  logic [5:0]      w_shift;
  logic [4:0]      w_rem_next;
  logic [13:0]     w_q_next;
  logic [9:0]      w_quot;

  assign w_tick        = (r_ms_cnt == MS_LAST);
  assign w_store_entry = (bus.machine_state == S_STORAGE) && (r_prev_state != S_STORAGE);
  assign w_avg_entry   = (bus.machine_state == S_AVERAGE) && (r_prev_state != S_AVERAGE);

  // Debounced level follows the synchronized button only after it has
  // disagreed for DEBOUNCE_CYC consecutive cycles; press is its rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_press    <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= bus.btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      r_press   <= r_db_level & ~r_db_prev;
      if (r_sync2 != r_db_level) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ms_cnt     <= '0;
      r_rt         <= '0;
      r_prev_state <= S_IDLE;
    end else begin
      r_prev_state <= bus.machine_state;
      if (bus.machine_state == S_CLR_CNT1 || bus.machine_state == S_CLR_CNT2)
        r_ms_cnt <= '0;
      else if (w_tick)
        r_ms_cnt <= '0;
      else
        r_ms_cnt <= r_ms_cnt + MS_W'(1);

      if (bus.machine_state == S_IDLE || bus.machine_state == S_CLR_CNT1)
        r_rt <= '0;
      else if (bus.machine_state == S_START && w_tick && !r_press && r_rt != RT_MAX)
        r_rt <= r_rt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum[0] <= '0;
      r_sum[1] <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else if (bus.machine_state == S_IDLE) begin
      r_sum[0] <= '0;
      r_sum[1] <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else if (w_store_entry && r_cnt[bus.cur_player] != TRIALS_C) begin
      r_sum[bus.cur_player] <= r_sum[bus.cur_player] + 14'(r_rt);
      r_cnt[bus.cur_player] <= r_cnt[bus.cur_player] + 5'd1;
    end
  end

  // One restoring step per cycle; the dividend shifts out of r_div_q as the
  // quotient bits shift in, so after 14 steps r_div_q holds the quotient.
  assign w_shift    = {r_div_rem, r_div_q[13]};
  assign w_fit      = (w_shift >= {1'b0, r_div_d});
  assign w_rem_next = w_fit ? 5'(w_shift - {1'b0, r_div_d}) : w_shift[4:0];
  assign w_q_next   = {r_div_q[12:0], w_fit};
  assign w_quot     = (r_div_d == 5'd0) ? 10'd0 : w_q_next[9:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_div_player <= 1'b0;
      r_div_q      <= '0;
      r_div_rem    <= '0;
      r_div_d      <= '0;
      r_step       <= '0;
      r_avg_a      <= '0;
      r_avg_b      <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.machine_state == S_IDLE) begin
        r_busy  <= 1'b0;
        r_avg_a <= '0;
        r_avg_b <= '0;
      end else if (r_busy) begin
        r_div_q   <= w_q_next;
        r_div_rem <= w_rem_next;
        r_step    <= r_step + 4'd1;
        if (r_step == 4'd13) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_div_player) r_avg_a <= w_quot;
          else              r_avg_b <= w_quot;
        end
      end else if (w_avg_entry) begin
        r_busy       <= 1'b1;
        r_step       <= '0;
        r_div_player <= bus.cur_player;
        r_div_q      <= r_sum[bus.cur_player];
        r_div_rem    <= '0;
        r_div_d      <= r_cnt[bus.cur_player];
      end
    end
  end

  assign bus.press            = r_press;
  assign bus.false_start      = r_press & (bus.machine_state == S_WAIT);
  assign bus.react_time       = r_rt;
  assign bus.avr_react_time_A = r_avg_a;
  assign bus.avr_react_time_B = r_avg_b;
  assign bus.avg_busy         = r_busy;
  assign bus.avg_done         = r_done;

endmodule

// File: tb/tb_reaction_recorder.sv
// Bench for reaction_recorder: randomized trials checked against a queue-based
// model of trial times and per-player averages.
module tb_reaction_recorder;
  localparam int MS = 10;
  localparam int DB = 4;
  localparam int TR = 5;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT     = 3'd1;
  localparam logic [2:0] ST_CLR_CNT1 = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_STORAGE  = 3'd4;
  localparam logic [2:0] ST_AVERAGE  = 3'd6;
  localparam logic [2:0] ST_COMPARE  = 3'd7;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  reaction_recorder_if bus_if();

  reaction_recorder #(.MS_DIV(MS), .DEBOUNCE_CYC(DB), .TRIALS(TR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int trials_a[$];
  int trials_b[$];
  int exp_avg_a = 0;
  int exp_avg_b = 0;
  int last_rt = 0;

  // Average over the first TR accepted trials of a player; 0 with none.
  function automatic int model_avg(input bit p);
    int n, s;
    n = 0;
    s = 0;
    if (p) begin
      n = (trials_a.size() < TR) ? trials_a.size() : TR;
      for (int i = 0; i < n; i++) s += trials_a[i];
    end else begin
      n = (trials_b.size() < TR) ? trials_b.size() : TR;
      for (int i = 0; i < n; i++) s += trials_b[i];
    end
    return (n == 0) ? 0 : s / n;
  endfunction

  task automatic model_clear();
    trials_a.delete();
    trials_b.delete();
    exp_avg_a = 0;
    exp_avg_b = 0;
    last_rt = 0;
  endtask

  task automatic test_reset();
    bus_if.machine_state = ST_IDLE;
    bus_if.cur_player = 1'b0;
    bus_if.btn = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.react_time !== 10'd0) begin errors++; $display("FAIL reset_rt: got %0d expected 0", bus_if.react_time); end
    checks++;
    if ({bus_if.avr_react_time_A, bus_if.avr_react_time_B} !== 20'd0) begin
      errors++; $display("FAIL reset_avg: got A=%0d B=%0d expected 0", bus_if.avr_react_time_A, bus_if.avr_react_time_B);
    end
    checks++;
    if ({bus_if.press, bus_if.false_start, bus_if.avg_busy, bus_if.avg_done} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {bus_if.press, bus_if.false_start, bus_if.avg_busy, bus_if.avg_done});
    end
    rstn = 1'b1;
  endtask

  task automatic test_debounce();
    int glen, npress, first_k, nfs;
    @(negedge clk); bus_if.machine_state = ST_COMPARE;
    glen = $urandom_range(1, DB - 1);
    @(negedge clk); bus_if.btn = 1'b1;
    repeat (glen) @(negedge clk);
    bus_if.btn = 1'b0;
    npress = 0;
    for (int k = 0; k < 3 * DB + 6; k++) begin
      @(posedge clk); #1;
      if (bus_if.press === 1'b1) npress++;
    end
    checks++;
    if (npress != 0) begin errors++; $display("FAIL glitch_press: got %0d pulses expected 0 (glitch %0d)", npress, glen); end

    @(negedge clk); bus_if.btn = 1'b1;
    npress = 0; nfs = 0; first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus_if.press === 1'b1) begin npress++; if (first_k < 0) first_k = k; end
      if (bus_if.false_start === 1'b1) nfs++;
      if (k == 10) begin @(negedge clk); bus_if.btn = 1'b0; end
    end
    checks++;
    if (npress != 1) begin errors++; $display("FAIL hold_press_count: got %0d expected 1", npress); end
    checks++;
    if (first_k != DB + 3) begin errors++; $display("FAIL hold_press_latency: got edge %0d expected %0d", first_k, DB + 3); end
    checks++;
    if (nfs != 0) begin errors++; $display("FAIL fs_outside_wait: got %0d expected 0", nfs); end
  endtask

  // Press is timed so the DUT samples it on START edge kp; kp on a tick edge
  // means that tick is not counted.
  task automatic run_trial(input bit p, input int n, input bit coincide);
    int kp, t, exp_rt, npress;
    kp = coincide ? MS * n : MS * n + 3;
    t = kp - DB - 3;
    exp_rt = coincide ? n - 1 : n;
    if (exp_rt > 999) exp_rt = 999;
    @(negedge clk); bus_if.cur_player = p; bus_if.machine_state = ST_CLR_CNT1;
    @(negedge clk); bus_if.machine_state = ST_START;
    for (int k = 1; k < kp; k++) begin
      @(negedge clk);
      if (k + 1 == t) bus_if.btn = 1'b1;
    end
    @(negedge clk); bus_if.machine_state = ST_STORAGE; bus_if.btn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.react_time !== 10'(exp_rt)) begin
      errors++; $display("FAIL trial_rt: got %0d expected %0d (n=%0d coincide=%0d)", bus_if.react_time, exp_rt, n, coincide);
    end
    if (p) trials_a.push_back(exp_rt); else trials_b.push_back(exp_rt);
    last_rt = exp_rt;
    @(negedge clk); bus_if.machine_state = ST_COMPARE;
    npress = 0;
    repeat (DB + 4) begin
      @(posedge clk); #1;
      if (bus_if.press === 1'b1) npress++;
    end
    checks++;
    if (npress != 0 || bus_if.react_time !== 10'(exp_rt)) begin
      errors++; $display("FAIL trial_hold: got rt=%0d release_pulses=%0d expected rt=%0d pulses=0", bus_if.react_time, npress, exp_rt);
    end
  endtask

  task automatic do_average(input bit p);
    int exp, exp_other, ndone, done_k;
    logic [9:0] got, got_other;
    exp = model_avg(p);
    exp_other = p ? exp_avg_b : exp_avg_a;
    @(negedge clk); bus_if.cur_player = p; bus_if.machine_state = ST_AVERAGE;
    ndone = 0; done_k = -1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (bus_if.avg_done === 1'b1) begin ndone++; done_k = k; end
      if (k == 1 || k == 14) begin
        checks++;
        if (bus_if.avg_busy !== 1'b1) begin errors++; $display("FAIL avg_busy_high: got %b at edge %0d expected 1", bus_if.avg_busy, k); end
      end
      if (k == 15) begin
        checks++;
        if (bus_if.avg_busy !== 1'b0) begin errors++; $display("FAIL avg_busy_low: got %b at edge 15 expected 0", bus_if.avg_busy); end
      end
      if (k == 1) begin @(negedge clk); bus_if.machine_state = ST_COMPARE; bus_if.cur_player = !p; end
      if (k == 3) begin @(negedge clk); bus_if.machine_state = ST_AVERAGE; end
      if (k == 5) begin @(negedge clk); bus_if.machine_state = ST_COMPARE; end
    end
    checks++;
    if (ndone != 1 || done_k != 15) begin errors++; $display("FAIL avg_done: got %0d pulses at edge %0d expected 1 at 15", ndone, done_k); end
    got = p ? bus_if.avr_react_time_A : bus_if.avr_react_time_B;
    got_other = p ? bus_if.avr_react_time_B : bus_if.avr_react_time_A;
    checks++;
    if (got !== 10'(exp)) begin errors++; $display("FAIL avg_value: player %0d got %0d expected %0d", p, got, exp); end
    checks++;
    if (got_other !== 10'(exp_other)) begin errors++; $display("FAIL avg_other: player %0d got %0d expected %0d", !p, got_other, exp_other); end
    if (p) exp_avg_a = exp; else exp_avg_b = exp;
  endtask

  task automatic go_idle();
    @(negedge clk); bus_if.machine_state = ST_IDLE;
    @(negedge clk); bus_if.machine_state = ST_COMPARE;
    model_clear();
  endtask

  task automatic test_limits();
    go_idle();
    @(negedge clk); bus_if.cur_player = 1'b1; bus_if.machine_state = ST_CLR_CNT1;
    @(negedge clk); bus_if.machine_state = ST_START;
    for (int k = 1; k <= 1200 * MS; k++) begin
      @(posedge clk); #1;
      if (k == MS * 999 - 1) begin
        checks++;
        if (bus_if.react_time !== 10'd998) begin errors++; $display("FAIL sat_before: got %0d expected 998", bus_if.react_time); end
      end
    end
    checks++;
    if (bus_if.react_time !== 10'd999) begin errors++; $display("FAIL sat_999: got %0d expected 999", bus_if.react_time); end
    @(negedge clk); bus_if.machine_state = ST_COMPARE;
    repeat (6) begin
      @(negedge clk); bus_if.machine_state = ST_STORAGE;
      @(negedge clk); bus_if.machine_state = ST_COMPARE;
      trials_a.push_back(999);
    end
    do_average(1'b1);
    do_average(1'b0);
  endtask

  task automatic test_average_spec();
    go_idle();
    @(posedge clk); #1;
    checks++;
    if ({bus_if.avr_react_time_A, bus_if.avr_react_time_B} !== 20'd0) begin
      errors++; $display("FAIL idle_clear: got A=%0d B=%0d expected 0", bus_if.avr_react_time_A, bus_if.avr_react_time_B);
    end
    run_trial(1'b1, 200, 1'b0);
    run_trial(1'b1, 302, 1'b1);
    run_trial(1'b1, 150, 1'b0);
    do_average(1'b1);
  endtask

  task automatic test_random();
    int ntr;
    go_idle();
    ntr = $urandom_range(6, 10);
    for (int i = 0; i < ntr; i++)
      run_trial(1'($urandom_range(0, 1)), $urandom_range(1, 30), 1'($urandom_range(0, 1)));
    do_average(1'b1);
    do_average(1'b0);
  endtask

  task automatic test_false_start();
    int np, nf, k_both;
    @(negedge clk); bus_if.machine_state = ST_WAIT;
    @(negedge clk); bus_if.btn = 1'b1;
    np = 0; nf = 0; k_both = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus_if.press === 1'b1) np++;
      if (bus_if.false_start === 1'b1) nf++;
      if (bus_if.press === 1'b1 && bus_if.false_start === 1'b1) k_both = k;
    end
    checks++;
    if (np != 1 || nf != 1 || k_both != DB + 3) begin
      errors++; $display("FAIL false_start: got press=%0d fs=%0d together@%0d expected 1,1,@%0d", np, nf, k_both, DB + 3);
    end
    checks++;
    if (bus_if.react_time !== 10'(last_rt)) begin errors++; $display("FAIL fs_rt_hold: got %0d expected %0d", bus_if.react_time, last_rt); end
    @(negedge clk); bus_if.btn = 1'b0; bus_if.machine_state = ST_COMPARE;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid_start();
    @(negedge clk); bus_if.cur_player = 1'b1; bus_if.machine_state = ST_CLR_CNT1;
    @(negedge clk); bus_if.machine_state = ST_START;
    repeat (35) @(negedge clk);
    checks++;
    if (bus_if.react_time !== 10'd3) begin errors++; $display("FAIL pre_reset_rt: got %0d expected 3", bus_if.react_time); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus_if.react_time, bus_if.avr_react_time_A, bus_if.avr_react_time_B} !== 30'd0 ||
        {bus_if.press, bus_if.false_start, bus_if.avg_busy, bus_if.avg_done} !== 4'b0) begin
      errors++; $display("FAIL async_reset: got rt=%0d A=%0d B=%0d expected all 0",
                         bus_if.react_time, bus_if.avr_react_time_A, bus_if.avr_react_time_B);
    end
    @(negedge clk); bus_if.machine_state = ST_IDLE; rstn = 1'b1;
    @(negedge clk); bus_if.machine_state = ST_COMPARE;
    model_clear();
  endtask

  task automatic test_abort();
    int ndone;
    run_trial(1'b1, 5, 1'b0);
    do_average(1'b1);
    run_trial(1'b1, 7, 1'b0);
    @(negedge clk); bus_if.cur_player = 1'b1; bus_if.machine_state = ST_AVERAGE;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (bus_if.avg_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", bus_if.avg_busy); end
    @(negedge clk); bus_if.machine_state = ST_IDLE;
    @(posedge clk); #1;
    checks++;
    if (bus_if.avg_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", bus_if.avg_busy); end
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_if.avg_done === 1'b1 || bus_if.avg_busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_done: got %0d busy/done cycles expected 0", ndone); end
    checks++;
    if ({bus_if.avr_react_time_A, bus_if.avr_react_time_B, bus_if.react_time} !== 30'd0) begin
      errors++; $display("FAIL abort_clear: got A=%0d B=%0d rt=%0d expected 0", bus_if.avr_react_time_A, bus_if.avr_react_time_B, bus_if.react_time);
    end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_debounce();
    run_trial(1'b1, $urandom_range(20, 60), 1'b0);
    run_trial(1'b0, $urandom_range(20, 60), 1'b1);
    test_limits();
    test_average_spec();
    test_random();
    test_false_start();
    test_reset_mid_start();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_recorder.md
# reaction_recorder

Measures each player's reaction time in milliseconds, debounces the player's push-button and keeps per-player running sums and averages. It sits beside the display path and is driven by the same 3-bit machine state. It produces `react_time`, `avr_react_time_A` and `avr_react_time_B` for the display, and a debounced `press` pulse back to the control state machine.

## Interface
- `MS_DIV`, 1000: clk cycles per millisecond tick (1 MHz clk).
- `DEBOUNCE_CYC`, 20000: cycles the synchronized button level must stay stable before it is accepted.
- `TRIALS`, 5: maximum trials accumulated per player. Legal range 1..16.
- `clk` in 1: system clock. One clock domain.
- `rstn` in 1: reset, asynchronous, active-low.
- `machine_state` in 3: IDLE=0, WAIT=1, CLR_CNT1=2, START=3, STORAGE=4, CLR_CNT2=5, AVERAGE=6, COMPARE=7.
- `cur_player` in 1: 1 = player A, 0 = player B.
- `btn` in 1: raw, asynchronous push-button input, active-high.
- `press` out 1: one-cycle pulse on the accepted rising edge of the debounced button.
- `false_start` out 1: one-cycle pulse, equal to `press` while the state is WAIT.
- `react_time` out 10: current or last reaction time in ms, range 0..999.
- `avr_react_time_A` out 10: player A average in ms.
- `avr_react_time_B` out 10: player B average in ms.
- `avg_busy` out 1: the divider is running.
- `avg_done` out 1: one-cycle pulse when an average is written.

## Operation
- **Button path**
  - 2-FF synchronizer feeds a stability counter.
  - The debounced level updates only after the synchronized level differs from it for `DEBOUNCE_CYC` consecutive cycles. Any glitch restarts the count.
  - `press` fires on a debounced 0→1 transition only. Release produces no pulse.
- **Millisecond prescaler**
  - 0..`MS_DIV`-1 counter. The tick fires when it wraps.
  - Cleared in CLR_CNT1 and CLR_CNT2. Free-running otherwise.
- **`react_time`**
  - Cleared to 0 in IDLE and CLR_CNT1.
  - In START, increments on each tick and saturates at 999.
  - A tick coinciding with `press` is not counted.
  - Held in every other state.
- **Accumulation**
  - On the first cycle of STORAGE (previous state ≠ STORAGE), `react_time` is added to `sum[cur_player]` (14-bit) and `cnt[cur_player]` (5-bit) increments.
  - If `cnt` already equals `TRIALS`, the entry is ignored and nothing changes.
- **Averaging**
  - On the first cycle of AVERAGE, `cur_player`, `sum` and `cnt` are latched and a 14-bit restoring divider starts, one quotient bit per cycle.
  - Result is floor(sum/cnt). If `cnt`=0, the result is 0.
  - The quotient is written to the latched player's average register.
  - The divide runs to completion even if the state leaves AVERAGE. A new AVERAGE entry while busy is ignored.
- **IDLE**
  - Clears `sum`, `cnt` and both averages for both players.
  - Aborts any divide in progress: `avg_busy`→0 and no `avg_done`.
- COMPARE and CLR_CNT2 have no side effects beyond the prescaler clear in CLR_CNT2.

## Timing
- **Reset**: all outputs are 0. Debounced level = 0, synchronizer = 0, all counters, sums and averages = 0.
- **`press` latency**: a `btn` change stable from edge t produces `press` at edge t+2+`DEBOUNCE_CYC`.
- **`react_time` first increment**: `MS_DIV` cycles after the first START cycle, provided CLR_CNT1 preceded START.
- **Accumulation**: the `sum`/`cnt` update is visible one cycle after the STORAGE entry edge.
- **Divide**:
  - `avg_busy` rises the cycle after the AVERAGE entry edge and stays high 14 cycles.
  - The average register and the `avg_done` pulse update in the cycle `avg_busy` falls, i.e. 15 cycles after entry.
- **Simultaneous events**:
  - IDLE takes precedence over STORAGE/AVERAGE entry and an in-flight divide.
  - A `press` in the START cycle that ends the count freezes the value of the previous cycle.

## Test plan
- **Debounce**: `MS_DIV`=10, `DEBOUNCE_CYC`=4. `btn` glitch high for 3 cycles → no `press`. `btn` high for 10 cycles → exactly one `press`, 6 cycles after the rise.
- **Timing**: CLR_CNT1 → START. `btn` pressed after 250 ms ticks → `react_time`=250 and held through STORAGE. Holding START 1200 ms → saturates at 999.
- **Averaging**: player A trials 200, 301, 150 via three STORAGE entries, then AVERAGE → `avr_react_time_A`=217 at 15 cycles, single `avg_done`, `avr_react_time_B`=0.
- **Limits**: 6 STORAGE entries with `TRIALS`=5, each 999 → sum 4995, cnt 5, average 999. AVERAGE for player B with no trials → 0.
- **False start**: press during WAIT → `false_start` and `press` pulse together, `react_time` unchanged.
- **Abort/reset**: IDLE 5 cycles into a divide → `avg_busy` 0 next cycle, no `avg_done`, averages 0. `rstn` low mid-START → all outputs 0 immediately.
